// File: rtl/cv32e40p_ft_health_ctrl.sv
// Health supervisor for triplicated FT units: force-break command sequencing, degradation/fatal tracking, irq.
// Optional per-unit error counters enabled by defining CV32E40P_FT_ERR_COUNTERS_EN.
module cv32e40p_ft_health_ctrl #(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TMO     = 15
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_UNITS-1:0][2:0]           is_broken_i,
    input  logic [N_UNITS-1:0]                err_detected_i,
    input  logic [N_UNITS-1:0]                err_corrected_i,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic [$clog2(N_UNITS)-1:0]        cmd_unit_i,
    input  logic [1:0]                        cmd_replica_i,
    input  logic                              cmd_op_i,
    output logic                              cmd_err_o,
    output logic                              flush_req_o,
    input  logic                              flush_ack_i,
    output logic [N_UNITS-1:0][2:0]           set_broken_o,
    output logic                              degraded_o,
    output logic                              fatal_o,
    output logic [$clog2(N_UNITS)-1:0]        fatal_unit_o,
    output logic                              irq_o,
    input  logic [$clog2(N_UNITS)-1:0]        rd_unit_i,
    output logic [CNT_W-1:0]                  rd_cnt_o
);

    localparam int unsigned UW = $clog2(N_UNITS);
    localparam int unsigned TW = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        APPLY  = 3'd2,
        SETTLE = 3'd3,
        FATAL  = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [UW-1:0]            tgt_unit_q;
    logic [1:0]               tgt_rep_q;
    logic [N_UNITS-1:0][2:0]  brk_q;

    logic                     fatal_det;
    logic [UW-1:0]            fatal_idx;
    logic                     degr_c;
    logic                     brk_rise;
    logic                     unit_oor;
    logic                     cmd_bad;
    logic                     accept_brk;
    logic                     reject_evt;
    logic                     timeout_evt;
    logic                     clr_evt;

    logic                     cmd_ready_d;
    logic                     cmd_err_d;
    logic                     flush_req_d;
    logic [N_UNITS-1:0][2:0]  set_broken_d;
    logic                     degraded_d;
    logic                     fatal_d;
    logic [UW-1:0]            fatal_unit_d;
    logic                     irq_d;

    // Per-unit replica health: two-or-more broken is fatal (lowest index wins), exactly one is degraded
    always_comb begin
        fatal_det = 1'b0;
        fatal_idx = '0;
        degr_c    = 1'b0;
        for (int u = N_UNITS - 1; u >= 0; u--) begin
            if ((is_broken_i[u][0] & is_broken_i[u][1]) |
                (is_broken_i[u][0] & is_broken_i[u][2]) |
                (is_broken_i[u][1] & is_broken_i[u][2])) begin
                fatal_det = 1'b1;
                fatal_idx = UW'(u);
            end else if (|is_broken_i[u]) begin
                degr_c = 1'b1;
            end
        end
    end

    assign brk_rise = |(is_broken_i & ~brk_q);
    assign unit_oor = ({1'b0, cmd_unit_i} >= (UW + 1)'(N_UNITS));
    assign cmd_bad  = unit_oor || (cmd_replica_i == 2'd3) || (|is_broken_i[cmd_unit_i]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        accept_brk  = 1'b0;
        reject_evt  = 1'b0;
        timeout_evt = 1'b0;
        clr_evt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_op_i) begin
                        clr_evt = 1'b1;
                    end else if (cmd_bad) begin
                        reject_evt = 1'b1;
                    end else begin
                        accept_brk = 1'b1;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_ack_i) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = SETTLE;
                tmo_d   = '0;
            end
            SETTLE: begin
                if (is_broken_i[tgt_unit_q][tgt_rep_q]) begin
                    state_d = IDLE;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    state_d     = IDLE;
                    timeout_evt = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            FATAL: state_d = FATAL;
            default: state_d = IDLE;
        endcase
        // Fatal wins over any in-flight or simultaneous command
        if (fatal_det) begin
            state_d     = FATAL;
            accept_brk  = 1'b0;
            reject_evt  = 1'b0;
            timeout_evt = 1'b0;
            clr_evt     = 1'b0;
        end
    end

    always_comb begin
        cmd_ready_d  = (state_d == IDLE);
        flush_req_d  = (state_d == FLUSH);
        fatal_d      = (state_d == FATAL);
        cmd_err_d    = reject_evt | timeout_evt;
        degraded_d   = degr_c;
        set_broken_d = '0;
        if (state_d == APPLY) begin
            set_broken_d[tgt_unit_q][tgt_rep_q] = 1'b1;
        end
        fatal_unit_d = fatal_unit_o;
        if ((state_d == FATAL) && (state_q != FATAL)) begin
            fatal_unit_d = fatal_idx;
        end
        irq_d = brk_rise | ((state_d == FATAL) && (state_q != FATAL));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready_o  <= 1'b1;
            cmd_err_o    <= 1'b0;
            flush_req_o  <= 1'b0;
            set_broken_o <= '0;
            degraded_o   <= 1'b0;
            fatal_o      <= 1'b0;
            fatal_unit_o <= '0;
            irq_o        <= 1'b0;
            brk_q        <= '0;
            tmo_q        <= '0;
            tgt_unit_q   <= '0;
            tgt_rep_q    <= '0;
        end else begin
            cmd_ready_o  <= cmd_ready_d;
            cmd_err_o    <= cmd_err_d;
            flush_req_o  <= flush_req_d;
            set_broken_o <= set_broken_d;
            degraded_o   <= degraded_d;
            fatal_o      <= fatal_d;
            fatal_unit_o <= fatal_unit_d;
            irq_o        <= irq_d;
            brk_q        <= is_broken_i;
            tmo_q        <= tmo_d;
            if (accept_brk) begin
                tgt_unit_q <= cmd_unit_i;
                tgt_rep_q  <= cmd_replica_i;
            end
        end
    end

`ifdef CV32E40P_FT_ERR_COUNTERS_EN
    logic [N_UNITS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]              rd_cnt_d;
    logic                          unused_ok;

    assign unused_ok = ^err_corrected_i;

    // Saturating per-unit error counters; a clear command zeroes them all
    always_comb begin
        cnt_d = cnt_q;
        for (int u = 0; u < N_UNITS; u++) begin
            if (err_detected_i[u] && !(&cnt_q[u])) begin
                cnt_d[u] = cnt_q[u] + CNT_W'(1);
            end
        end
        if (clr_evt) begin
            cnt_d = '0;
        end
        rd_cnt_d = '0;
        if ({1'b0, rd_unit_i} < (UW + 1)'(N_UNITS)) begin
            rd_cnt_d = cnt_q[rd_unit_i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rd_cnt_o <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_cnt_o <= rd_cnt_d;
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{err_detected_i, err_corrected_i, rd_unit_i, clr_evt};
    assign rd_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_ft_health_ctrl.sv
// Directed self-checking bench for cv32e40p_ft_health_ctrl (N_UNITS=4, CNT_W=4, TMO=15).
module tb_cv32e40p_ft_health_ctrl;

    logic             clk;
    logic             rst_n;
    logic [3:0][2:0]  is_broken_i;
    logic [3:0]       err_detected_i;
    logic [3:0]       err_corrected_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_unit_i;
    logic [1:0]       cmd_replica_i;
    logic             cmd_op_i;
    logic             cmd_err_o;
    logic             flush_req_o;
    logic             flush_ack_i;
    logic [3:0][2:0]  set_broken_o;
    logic             degraded_o;
    logic             fatal_o;
    logic [1:0]       fatal_unit_o;
    logic             irq_o;
    logic [1:0]       rd_unit_i;
    logic [3:0]       rd_cnt_o;

    int n_checks = 0;
    int n_fails  = 0;

    cv32e40p_ft_health_ctrl #(
        .N_UNITS(4),
        .CNT_W  (4),
        .TMO    (15)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .is_broken_i    (is_broken_i),
        .err_detected_i (err_detected_i),
        .err_corrected_i(err_corrected_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_unit_i     (cmd_unit_i),
        .cmd_replica_i  (cmd_replica_i),
        .cmd_op_i       (cmd_op_i),
        .cmd_err_o      (cmd_err_o),
        .flush_req_o    (flush_req_o),
        .flush_ack_i    (flush_ack_i),
        .set_broken_o   (set_broken_o),
        .degraded_o     (degraded_o),
        .fatal_o        (fatal_o),
        .fatal_unit_o   (fatal_unit_o),
        .irq_o          (irq_o),
        .rd_unit_i      (rd_unit_i),
        .rd_cnt_o       (rd_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] unit, input logic [1:0] rep, input logic op);
        cmd_valid_i   = 1'b1;
        cmd_unit_i    = unit;
        cmd_replica_i = rep;
        cmd_op_i      = op;
        tick();
        cmd_valid_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fl;
        int n;
        rst_n           = 1'b0;
        is_broken_i     = '0;
        err_detected_i  = '0;
        err_corrected_i = '0;
        cmd_valid_i     = 1'b0;
        cmd_unit_i      = '0;
        cmd_replica_i   = '0;
        cmd_op_i        = 1'b0;
        flush_ack_i     = 1'b0;
        rd_unit_i       = '0;
        tick();
        tick();
        chk("rst_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_flush", 32'(flush_req_o), 32'd0);
        chk("rst_setbrk", 32'(set_broken_o), 32'd0);
        chk("rst_degr", 32'(degraded_o), 32'd0);
        chk("rst_fatal", 32'(fatal_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_err", 32'(cmd_err_o), 32'd0);
        chk("rst_rdcnt", 32'(rd_cnt_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Force-break unit 2 replica 1, ack in third flush cycle, monitor responds 2 cycles after APPLY
        send_cmd(2'd2, 2'd1, 1'b0);
        chk("fb_ready_low", 32'(cmd_ready_o), 32'd0);
        fl = 0;
        for (int i = 0; i < 3; i++) begin
            if (flush_req_o) fl++;
            chk("fb_no_setbrk_flush", 32'(set_broken_o), 32'd0);
            if (i == 2) flush_ack_i = 1'b1;
            tick();
        end
        flush_ack_i = 1'b0;
        chk("fb_flush_cycles", 32'(fl), 32'd3);
        chk("fb_apply_setbrk", 32'(set_broken_o), 32'h080);
        chk("fb_apply_flush_low", 32'(flush_req_o), 32'd0);
        tick();
        chk("fb_settle_setbrk", 32'(set_broken_o), 32'd0);
        tick();
        is_broken_i[2][1] = 1'b1;
        tick();
        chk("fb_irq", 32'(irq_o), 32'd1);
        chk("fb_degraded", 32'(degraded_o), 32'd1);
        chk("fb_idle_ready", 32'(cmd_ready_o), 32'd1);
        chk("fb_no_err", 32'(cmd_err_o), 32'd0);
        tick();
        chk("fb_irq_one_cycle", 32'(irq_o), 32'd0);

        // Rejections: replica 3, then a unit that already has a broken replica
        send_cmd(2'd0, 2'd3, 1'b0);
        chk("rej_rep3_err", 32'(cmd_err_o), 32'd1);
        chk("rej_rep3_ready", 32'(cmd_ready_o), 32'd1);
        tick();
        chk("rej_rep3_err_pulse", 32'(cmd_err_o), 32'd0);
        chk("rej_rep3_setbrk", 32'(set_broken_o), 32'd0);
        send_cmd(2'd2, 2'd0, 1'b0);
        chk("rej_degr_err", 32'(cmd_err_o), 32'd1);
        tick();
        chk("rej_degr_flush", 32'(flush_req_o), 32'd0);
        chk("rej_degr_setbrk", 32'(set_broken_o), 32'd0);

        // Settle timeout: no monitor response
        send_cmd(2'd0, 2'd0, 1'b0);
        flush_ack_i = 1'b1;
        tick();
        flush_ack_i = 1'b0;
        chk("tmo_apply_setbrk", 32'(set_broken_o), 32'h001);
        n = 0;
        while (!cmd_err_o && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_latency", 32'(n), 32'd16);
        chk("tmo_ready", 32'(cmd_ready_o), 32'd1);
        tick();
        chk("tmo_err_pulse", 32'(cmd_err_o), 32'd0);

        // Reset during FLUSH aborts the command
        send_cmd(2'd1, 2'd2, 1'b0);
        chk("rstf_flush_high", 32'(flush_req_o), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rstf_flush_low", 32'(flush_req_o), 32'd0);
        chk("rstf_ready", 32'(cmd_ready_o), 32'd1);
        rst_n       = 1'b1;
        flush_ack_i = 1'b1;
        tick();
        chk("rstf_setbrk0", 32'(set_broken_o), 32'd0);
        tick();
        flush_ack_i = 1'b0;
        chk("rstf_setbrk1", 32'(set_broken_o), 32'd0);
        chk("rstf_degr_back", 32'(degraded_o), 32'd1);

        // Error counters (saturating); zero when the feature is compiled out
        err_detected_i[0] = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        err_detected_i[0] = 1'b0;
        tick();
`ifdef CV32E40P_FT_ERR_COUNTERS_EN
        chk("cnt_saturate", 32'(rd_cnt_o), 32'd15);
        rd_unit_i = 2'd1;
        tick();
        chk("cnt_other_unit", 32'(rd_cnt_o), 32'd0);
        rd_unit_i = 2'd0;
        tick();
        chk("cnt_still_sat", 32'(rd_cnt_o), 32'd15);
`else
        chk("cnt_disabled", 32'(rd_cnt_o), 32'd0);
`endif
        send_cmd(2'd0, 2'd0, 1'b1);
        chk("clr_no_err", 32'(cmd_err_o), 32'd0);
        chk("clr_ready", 32'(cmd_ready_o), 32'd1);
        tick();
        chk("clr_zero", 32'(rd_cnt_o), 32'd0);

        // Double breakage during SETTLE goes FATAL; lowest failing unit reported
        send_cmd(2'd0, 2'd1, 1'b0);
        flush_ack_i = 1'b1;
        tick();
        flush_ack_i = 1'b0;
        tick();
        is_broken_i[1] = 3'b011;
        is_broken_i[3] = 3'b111;
        tick();
        chk("fat_fatal", 32'(fatal_o), 32'd1);
        chk("fat_unit", 32'(fatal_unit_o), 32'd1);
        chk("fat_ready", 32'(cmd_ready_o), 32'd0);
        chk("fat_irq", 32'(irq_o), 32'd1);
        cmd_valid_i   = 1'b1;
        cmd_op_i      = 1'b0;
        cmd_unit_i    = 2'd0;
        cmd_replica_i = 2'd2;
        for (int i = 0; i < 3; i++) tick();
        cmd_valid_i = 1'b0;
        chk("fat_hold_ready", 32'(cmd_ready_o), 32'd0);
        chk("fat_hold_fatal", 32'(fatal_o), 32'd1);
        chk("fat_hold_setbrk", 32'(set_broken_o), 32'd0);
        chk("fat_hold_flush", 32'(flush_req_o), 32'd0);
        is_broken_i = '0;
        rst_n = 1'b0;
        tick();
        chk("fat_rst_fatal", 32'(fatal_o), 32'd0);
        chk("fat_rst_ready", 32'(cmd_ready_o), 32'd1);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cv32e40p_ft_health_ctrl.md
CV32E40P_FT_HEALTH_CTRL -- requirements
Module: cv32e40p_ft_health_ctrl

Interface
REQ-001 SHALL have parameter N_UNITS, default 4: number of triplicated FT units supervised (2..16).
REQ-002 SHALL have parameter CNT_W, default 16: width of per-unit error counters.
REQ-003 SHALL have parameter TMO, default 15: SETTLE timeout in cycles (1..255).
REQ-004 Port: clk  in  1  the single clock; all logic on its rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous and active-low.
REQ-006 Port: is_broken_i  in  N_UNITS x 3  per-unit replica broken flags from the breakage monitors.
REQ-007 Port: err_detected_i / err_corrected_i  in  N_UNITS each  per-unit voter flags.
REQ-008 Port: cmd_valid_i / cmd_ready_o  in/out  1  command handshake; transfer when both are high on a clock edge.
REQ-009 Port: cmd_unit_i  in  clog2(N_UNITS)  target unit; cmd_replica_i  in  2  target replica; cmd_op_i  in  1  (0 = force-break, 1 = clear counters).
REQ-010 Port: cmd_err_o  out  1  one-cycle pulse when a command is rejected.
REQ-011 Port: flush_req_o / flush_ack_i  out/in  1  pipeline-quiesce handshake.
REQ-012 Port: set_broken_o  out  N_UNITS x 3  drives the breakage monitors' set_broken_i.
REQ-013 Port: degraded_o  out  1; fatal_o  out  1; fatal_unit_o  out  clog2(N_UNITS); irq_o  out  1.
REQ-014 Port: rd_unit_i  in  clog2(N_UNITS); rd_cnt_o  out  CNT_W  counter read port.

Function
REQ-015 FSM states SHALL be IDLE, FLUSH, APPLY, SETTLE, FATAL; cmd_ready_o = 1 only in IDLE.
REQ-016 A force-break command SHALL be rejected (cmd_err_o pulse next cycle, stay IDLE) if unit >= N_UNITS, replica == 3, or the target unit already has any broken replica.
REQ-017 A clear command SHALL zero all counters the cycle after acceptance and stay in IDLE.
REQ-018 An accepted force-break SHALL go IDLE->FLUSH; flush_req_o SHALL be high throughout FLUSH and stay high until flush_ack_i is sampled high.
REQ-019 FLUSH->APPLY on flush_ack_i; set_broken_o SHALL pulse for exactly one cycle on the target bit in APPLY; then APPLY->SETTLE.
REQ-020 SETTLE->IDLE when the target is_broken_i bit is high, or after TMO cycles; on timeout cmd_err_o SHALL pulse.
REQ-021 degraded_o SHALL be registered: 1 when any unit has exactly one broken replica.
REQ-022 If any unit has two or more broken replicas, the FSM SHALL enter FATAL from any state the next cycle, with fatal_o = 1 and fatal_unit_o = lowest such index; FATAL is left only by reset.
REQ-023 irq_o SHALL pulse one cycle for each cycle in which any is_broken_i bit rises (edge versus the previous sample), and on FATAL entry.
REQ-024 Outside APPLY, set_broken_o SHALL be all-zero, and flush_req_o SHALL be low outside FLUSH.
REQ-025 Fatal detection SHALL take priority over an in-flight command and over a simultaneous cmd_valid_i.

Reset
REQ-026 While rst_n is low at a clock edge: state = IDLE, all outputs = 0 except cmd_ready_o = 1, counters = 0, edge-detect history = 0.
REQ-027 Reset asserted mid-command SHALL abort it with no set_broken_o pulse on the following cycle.

Configuration
REQ-028 Macro CV32E40P_FT_ERR_COUNTERS_EN defined: one CNT_W saturating counter per unit, +1 per cycle with err_detected_i set (never wraps past all-ones); rd_cnt_o = counter[rd_unit_i] registered, 1-cycle latency (0 if rd_unit_i >= N_UNITS).
REQ-029 Macro undefined: no counters; rd_cnt_o tied to 0; clear command accepted as a no-op.

Verification
REQ-030 Force-break unit 2 replica 1, flush_ack_i after 3 cycles, is_broken_i[2][1] rises 2 cycles after APPLY -> flush_req_o high 3 cycles, one set_broken_o[2][1] pulse, irq_o pulse, degraded_o = 1, back to IDLE.
REQ-031 Force-break with replica = 3, then a second force-break on a unit already degraded -> cmd_err_o pulse each time, set_broken_o stays 0.
REQ-032 is_broken_i[1] = 3'b011 arrives during SETTLE -> FATAL next cycle, fatal_unit_o = 1, cmd_ready_o = 0 until reset.
REQ-033 No is_broken_i response after APPLY -> cmd_err_o pulse after TMO = 15 cycles, return to IDLE.
REQ-034 With the macro defined, CNT_W = 4, hold err_detected_i[0] high 20 cycles -> rd_cnt_o = 15; clear command -> 0.
REQ-035 Reset pulsed during FLUSH -> IDLE, flush_req_o = 0, no set_broken_o pulse afterwards.
